// File: rtl/lane_judge.sv
// lane_judge: per-lane chart pointer and hit judge for the rhythm-game chart path.
// The block drives the chart ROM address. It compares the head entry (key_1)
// against song time and the synchronised lane key, and it emits one judgement
// per note, or one per hold body.
// Optional build macro: LANE_JUDGE_COMBO_EN adds a saturating combo counter output.
module lane_judge #(
    parameter int NOTE_COUNT  = 148,
    parameter int PERFECT_WIN = 3,
    parameter int GOOD_WIN    = 6,
    parameter int EARLY_WIN   = 10
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        start,
    input  logic [13:0] song_time,
    input  logic        key_down,
    output logic [7:0]  addr,
    input  logic [15:0] key_1,
    input  logic [15:0] key_2,
    input  logic [15:0] key_3,
    input  logic [15:0] key_4,
    output logic        judge_valid,
    output logic [1:0]  judge_code,
    output logic        hold_active,
    output logic        done
`ifdef LANE_JUDGE_COMBO_EN
    ,
    output logic [9:0]  combo
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

    localparam logic [1:0] T_TAP    = 2'b00;
    localparam logic [1:0] T_HSTART = 2'b01;
    localparam logic [1:0] T_HEND   = 2'b10;
    localparam logic [1:0] T_RSVD   = 2'b11;

    localparam logic [1:0] J_PERFECT = 2'b00;
    localparam logic [1:0] J_GOOD    = 2'b01;
    localparam logic [1:0] J_MISS    = 2'b10;
    localparam logic [1:0] J_BREAK   = 2'b11;

    localparam logic [8:0]         NOTE_END  = 9'(NOTE_COUNT);
    localparam logic signed [14:0] PERFECT_S = 15'(PERFECT_WIN);
    localparam logic signed [14:0] GOOD_S    = 15'(GOOD_WIN);
    localparam logic signed [14:0] EARLY_S   = 15'(EARLY_WIN);

    state_t state_reg;

    logic key_meta_reg, key_sync_reg, key_prev_reg;
    logic press_reg, rel_reg;

    logic [1:0]         head_type;
    logic [13:0]        head_time;
    logic signed [14:0] d;
    logic signed [14:0] d_abs;
    logic               in_range;
    logic [8:0]         step_one;
    logic [8:0]         step_two;
    logic [7:0]         miss_addr;
    logic               judge_fire;
    logic [1:0]         judge_kind;

    // The lookahead entries go only to the renderer. They are not used for judging.
    logic unused_lookahead;
    assign unused_lookahead = ^{key_2, key_3, key_4};

    assign head_type = key_1[15:14];
    assign head_time = key_1[13:0];
    assign d         = $signed({1'b0, song_time}) - $signed({1'b0, head_time});
    assign d_abs     = d[14] ? -d : d;
    assign in_range  = ({1'b0, addr} < NOTE_END);
    assign step_one  = {1'b0, addr} + 9'd1;
    assign step_two  = {1'b0, addr} + 9'd2;

    // A missed hold-start also skips its hold-end. The pointer never runs past the chart end.
    assign miss_addr = (head_type == T_HSTART) ?
                       ((step_two > NOTE_END) ? NOTE_END[7:0] : step_two[7:0]) :
                       step_one[7:0];

    // Synchronise the raw key level, then register the press and release strobes.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            key_meta_reg <= 1'b0;
            key_sync_reg <= 1'b0;
            key_prev_reg <= 1'b0;
            press_reg    <= 1'b0;
            rel_reg      <= 1'b0;
        end else begin
            key_meta_reg <= key_down;
            key_sync_reg <= key_meta_reg;
            key_prev_reg <= key_sync_reg;
            press_reg    <= key_sync_reg & ~key_prev_reg;
            rel_reg      <= ~key_sync_reg & key_prev_reg;
        end
    end

    // Decide whether the head entry is judged this cycle, and with which code.
    always_comb begin
        judge_fire = 1'b0;
        judge_kind = J_PERFECT;
        case (state_reg)
            RUN: begin
                if (in_range && (head_type == T_TAP || head_type == T_HSTART)) begin
                    if (d > GOOD_S) begin
                        judge_fire = 1'b1;
                        judge_kind = J_MISS;
                    end else if (press_reg && d_abs <= GOOD_S) begin
                        judge_fire = 1'b1;
                        judge_kind = (d_abs <= PERFECT_S) ? J_PERFECT : J_GOOD;
                    end else if (press_reg && d >= -EARLY_S && d < -GOOD_S) begin
                        judge_fire = 1'b1;
                        judge_kind = J_MISS;
                    end
                end
            end
            HOLD: begin
                if (head_type == T_HEND) begin
                    if (key_prev_reg && d >= 15'sd0) begin
                        judge_fire = 1'b1;
                        judge_kind = J_PERFECT;
                    end else if (rel_reg) begin
                        judge_fire = 1'b1;
                        judge_kind = (d >= -GOOD_S) ? J_PERFECT : J_BREAK;
                    end
                end
            end
            default: begin
                judge_fire = 1'b0;
            end
        endcase
    end

    // Main FSM. It updates the address pointer and the registered judge outputs. start overrides everything.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg   <= IDLE;
            addr        <= 8'd0;
            judge_valid <= 1'b0;
            judge_code  <= J_PERFECT;
            hold_active <= 1'b0;
            done        <= 1'b0;
        end else if (start) begin
            state_reg   <= RUN;
            addr        <= 8'd0;
            judge_valid <= 1'b0;
            hold_active <= 1'b0;
            done        <= 1'b0;
        end else begin
            judge_valid <= judge_fire;
            if (judge_fire) begin
                judge_code <= judge_kind;
            end
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                end
                RUN: begin
                    if (!in_range) begin
                        state_reg <= DONE;
                        done      <= 1'b1;
                    end else if (head_type == T_HEND || head_type == T_RSVD) begin
                        addr <= step_one[7:0];
                    end else if (judge_fire) begin
                        if (judge_kind == J_MISS) begin
                            addr <= miss_addr;
                        end else begin
                            addr <= step_one[7:0];
                            if (head_type == T_HSTART) begin
                                state_reg   <= HOLD;
                                hold_active <= 1'b1;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (head_type != T_HEND) begin
                        state_reg   <= RUN;
                        hold_active <= 1'b0;
                    end else if (judge_fire) begin
                        addr        <= step_one[7:0];
                        state_reg   <= RUN;
                        hold_active <= 1'b0;
                    end
                end
                DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef LANE_JUDGE_COMBO_EN
    // Combo counter. A hit counts up, saturating at 999. A miss, a hold-break or a start clears it.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            combo <= 10'd0;
        end else if (start) begin
            combo <= 10'd0;
        end else if (judge_fire) begin
            if (judge_kind == J_MISS || judge_kind == J_BREAK) begin
                combo <= 10'd0;
            end else if (combo != 10'd999) begin
                combo <= combo + 10'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lane_judge.sv
// tb_lane_judge: directed bench for lane_judge. It models the chart ROM locally
// and checks every expected value, worked out by hand, with immediate assertions.
module tb_lane_judge;

    localparam int NC = 14;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        start;
    logic [13:0] song_time;
    logic        key_down;
    logic [7:0]  addr;
    logic [15:0] key_1, key_2, key_3, key_4;
    logic        judge_valid;
    logic [1:0]  judge_code;
    logic        hold_active;
    logic        done;
`ifdef LANE_JUDGE_COMBO_EN
    logic [9:0]  combo;
`endif

    logic [15:0] rom [0:255];

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    assign key_1 = rom[addr];
    assign key_2 = rom[addr + 8'd1];
    assign key_3 = rom[addr + 8'd2];
    assign key_4 = rom[addr + 8'd3];

    lane_judge #(
        .NOTE_COUNT (NC),
        .PERFECT_WIN(3),
        .GOOD_WIN   (6),
        .EARLY_WIN  (10)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .start      (start),
        .song_time  (song_time),
        .key_down   (key_down),
        .addr       (addr),
        .key_1      (key_1),
        .key_2      (key_2),
        .key_3      (key_3),
        .key_4      (key_4),
        .judge_valid(judge_valid),
        .judge_code (judge_code),
        .hold_active(hold_active),
        .done       (done)
`ifdef LANE_JUDGE_COMBO_EN
        ,
        .combo      (combo)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic expect_judge(input string tag, input logic [1:0] code, input logic [7:0] a);
        chk({tag, "_valid"}, 32'(judge_valid), 1);
        chk({tag, "_code"}, 32'(judge_code), 32'(code));
        chk({tag, "_addr"}, 32'(addr), 32'(a));
        $display("txn %s: valid=%0d code=%0d addr=%0d hold=%0d", tag, judge_valid, judge_code, addr, hold_active);
    endtask

    // Press the key. The strobe must appear on exactly the 4th edge, for one cycle only.
    task automatic press_expect(input string tag, input logic [1:0] code, input logic [7:0] a);
        key_down = 1'b1;
        repeat (3) tick();
        chk({tag, "_early_strobe"}, 32'(judge_valid), 0);
        tick();
        expect_judge(tag, code, a);
        tick();
        chk({tag, "_one_shot"}, 32'(judge_valid), 0);
    endtask

    task automatic release_key();
        key_down = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[0]  = 16'd103;
        rom[1]  = 16'd125;
        rom[2]  = 16'd125;
        rom[3]  = 16'd125;
        rom[4]  = 16'd345;
        rom[5]  = 16'h4000 | 16'd2256;
        rom[6]  = 16'h8000 | 16'd2268;
        rom[7]  = 16'h4000 | 16'd2256;
        rom[8]  = 16'h8000 | 16'd2268;
        rom[9]  = 16'h8000 | 16'd500;
        rom[10] = 16'h4000 | 16'd2300;
        rom[11] = 16'h8000 | 16'd2312;
        rom[12] = 16'd3000;
        rom[13] = 16'h4000 | 16'd3000;

        Reset_n   = 1'b0;
        start     = 1'b0;
        key_down  = 1'b0;
        song_time = 14'd0;
        tick();
        tick();
        chk("rst_addr", 32'(addr), 0);
        chk("rst_valid", 32'(judge_valid), 0);
        chk("rst_code", 32'(judge_code), 0);
        chk("rst_hold", 32'(hold_active), 0);
        chk("rst_done", 32'(done), 0);
        Reset_n = 1'b1;
        tick();

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_addr", 32'(addr), 0);

        // Tap at t=103, press at 104: perfect
        song_time = 14'd104;
        press_expect("tap_perfect", 2'b00, 8'd1);
        release_key();

        // Tap at t=125, press at 120 (d=-5): good
        song_time = 14'd120;
        press_expect("tap_good", 2'b01, 8'd2);
        release_key();

        // Tap at t=125, press at 117 (d=-8): early miss
        song_time = 14'd117;
        press_expect("tap_early_miss", 2'b10, 8'd3);
        release_key();

        // Tap at t=125, press at 110 (d=-15): ignored
        song_time = 14'd110;
        key_down = 1'b1;
        repeat (5) tick();
        chk("ignored_valid", 32'(judge_valid), 0);
        chk("ignored_addr", 32'(addr), 3);
        release_key();
        song_time = 14'd200;
        tick();
        expect_judge("late_miss_125", 2'b10, 8'd4);

        // Tap at t=345, no press, ramp to 352: miss on the first tick past +6
        for (int st = 340; st <= 351; st++) begin
            song_time = 14'(st);
            tick();
            if (judge_valid !== 1'b0) chk("ramp_quiet", 32'(judge_valid), 0);
        end
        chk("ramp_addr_held", 32'(addr), 4);
        song_time = 14'd352;
        tick();
        expect_judge("ramp_miss_352", 2'b10, 8'd5);

        // Hold-start at t=2256, no press: miss skips the hold-end
        song_time = 14'd2262;
        tick();
        chk("hold_miss_quiet", 32'(judge_valid), 0);
        song_time = 14'd2263;
        tick();
        expect_judge("hold_start_miss", 2'b10, 8'd7);
        song_time = 14'd2256;

        // Hold 2256/2268 held through: perfect on entry, perfect at the end
        press_expect("hold_entry", 2'b00, 8'd8);
        chk("hold_active_on", 32'(hold_active), 1);
        song_time = 14'd2267;
        tick();
        chk("hold_mid_valid", 32'(judge_valid), 0);
        chk("hold_mid_active", 32'(hold_active), 1);
        song_time = 14'd2268;
        tick();
        expect_judge("hold_end_perfect", 2'b00, 8'd9);
        chk("hold_active_off", 32'(hold_active), 0);

        // An orphan hold-end at addr 9 is skipped in one cycle with no strobe
        tick();
        chk("orphan_valid", 32'(judge_valid), 0);
        chk("orphan_addr", 32'(addr), 10);
        release_key();

        // Hold 2300/2312, release at 2304 (d=-8): hold-break
        song_time = 14'd2300;
        press_expect("hold2_entry", 2'b00, 8'd11);
        song_time = 14'd2304;
        key_down = 1'b0;
        repeat (3) tick();
        chk("brk_pre_active", 32'(hold_active), 1);
        chk("brk_pre_valid", 32'(judge_valid), 0);
        tick();
        expect_judge("hold_break", 2'b11, 8'd12);
        chk("brk_active_off", 32'(hold_active), 0);

        // Run out the chart. The trailing hold-start miss saturates at NOTE_COUNT.
        song_time = 14'd4000;
        tick();
        expect_judge("tail_tap_miss", 2'b10, 8'd13);
        tick();
        expect_judge("tail_hold_miss_sat", 2'b10, 8'd14);
        tick();
        chk("done_set", 32'(done), 1);
        chk("done_valid", 32'(judge_valid), 0);
        tick();
        chk("done_held", 32'(done), 1);
        chk("done_addr", 32'(addr), 14);
        $display("txn done: done=%0d addr=%0d", done, addr);

        // Restart, enter a hold, then start again while the hold-end is due
        rom[0] = 16'h4000 | 16'd50;
        rom[1] = 16'h8000 | 16'd80;
        song_time = 14'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_addr", 32'(addr), 0);
        chk("restart_done", 32'(done), 0);
        song_time = 14'd50;
        press_expect("restart_hold", 2'b00, 8'd1);
        chk("restart_hold_active", 32'(hold_active), 1);
        song_time = 14'd80;
        start = 1'b1;
        tick();
        start = 1'b0;
        song_time = 14'd0;
        chk("start_in_hold_addr", 32'(addr), 0);
        chk("start_in_hold_active", 32'(hold_active), 0);
        chk("start_in_hold_valid", 32'(judge_valid), 0);
        tick();
        chk("start_in_hold_quiet", 32'(judge_valid), 0);
        $display("txn start_in_hold: addr=%0d hold=%0d valid=%0d", addr, hold_active, judge_valid);

        // Reset during a strobe clears the outputs at once
        song_time = 14'd57;
        tick();
        expect_judge("pre_reset_miss", 2'b10, 8'd2);
        Reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(judge_valid), 0);
        chk("async_rst_code", 32'(judge_code), 0);
        chk("async_rst_addr", 32'(addr), 0);
        $display("txn async_reset: valid=%0d code=%0d addr=%0d", judge_valid, judge_code, addr);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lane_judge.md
Name: lane_judge

Overview:
- Per-lane note scheduler and hit judge for the rhythm-game chart path.
- Drives the chart ROM address. Consumes the 4-entry lookahead window (key_1..key_4) that the ROM returns.
- Compares the head note against the running song-time counter and the lane's key input. Emits one judgement per note, or per hold body.
- key_1..key_4 also go in parallel to the lane renderer. This block owns only the address pointer and the judging.
- Chart entry format: [15:14] type (00 tap, 01 hold-start, 10 hold-end, 11 reserved); [13:0] timestamp in song ticks.

Parameters:
- NOTE_COUNT, 148, number of valid entries in this lane's chart; addr == NOTE_COUNT means chart exhausted.
- PERFECT_WIN, 3, +/- ticks for a perfect hit (inclusive).
- GOOD_WIN, 6, +/- ticks for a good hit (inclusive); a head later than this counts as missed.
- EARLY_WIN, 10, an early press within this many ticks (but outside GOOD_WIN) consumes the note as a miss.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; restart chart from entry 0 from any state.
- song_time  in  14  current song tick, monotonic, never wraps during a song.
- key_down  in  1  raw lane key level, asynchronous to Clk.
- addr  out  8  registered chart ROM address (head entry).
- key_1  in  16  chart entry at addr (combinational ROM, valid same cycle).
- key_2  in  16  entry addr+1 (unused for judging; port present for uniform hookup).
- key_3  in  16  entry addr+2 (unused).
- key_4  in  16  entry addr+3 (unused).
- judge_valid  out  1  one-cycle strobe.
- judge_code  out  2  00 perfect, 01 good, 10 miss, 11 hold-break; held until next strobe.
- hold_active  out  1  high while a hold body is being held.
- done  out  1  high in DONE.

Behaviour:
- Reset: addr=0, judge_valid=0, judge_code=00, hold_active=0, done=0, state=IDLE, key sync flops=0.
- key_down passes through a 2-flop synchroniser, then a third flop for edge detection.
  - press = rise on the synchronised level; rel = fall.
  - Press-to-strobe latency: exactly 4 Clk edges after key_down rises.
- Timing terms:
  - t = key_1[13:0].
  - d = song_time - t, computed as 15-bit signed.
  - |d| is evaluated in the same cycle as the press.
- States: IDLE, RUN, HOLD, DONE. At most one addr step (+1 or +2) per cycle. Judge outputs are registered; judge_valid is high the cycle after the deciding condition.
- IDLE: wait for start, then addr=0 and go to RUN.
- RUN, evaluated in priority order:
  1. addr >= NOTE_COUNT: go to DONE.
  2. key_1 type is 10 or 11 (orphan): addr+1, no judgement.
  3. d > GOOD_WIN: miss. Step is +1 for a tap, +2 for a hold-start (skips its hold-end), saturating at NOTE_COUNT.
  4. press with |d| <= PERFECT_WIN: perfect. With |d| <= GOOD_WIN: good. A tap steps +1. A hold-start steps +1 and goes to HOLD with hold_active=1.
  5. press with -EARLY_WIN <= d < -GOOD_WIN: miss. Step as in rule 3.
  6. Other presses are ignored.
- HOLD (key_1 is the hold-end; t is the end time):
  - song_time >= t while still held: perfect, addr+1, go to RUN.
  - rel with d >= -GOOD_WIN: perfect, addr+1, go to RUN.
  - rel with d < -GOOD_WIN: hold-break (11), addr+1, go to RUN.
  - hold_active drops in the same cycle judge_valid rises.
  - If key_1 in HOLD is not type 10 (malformed chart): go to RUN, no judgement.
- DONE: done=1; addr holds; only start leaves.
- start has priority over every state transition:
  - addr=0, hold_active=0, done=0, go to RUN.
  - A pending judgement in that cycle is dropped.
- Reset mid-hold or mid-strobe: all outputs return to reset values immediately (asynchronous).
- No song_time wrap handling; a song_time jump backwards is treated as legal. Pending notes simply wait.

Optional Feature:
- LANE_JUDGE_COMBO_EN
- Defined:
  - Adds output combo[9:0], reset 0.
  - +1 on perfect/good, saturates at 999.
  - Cleared on miss, hold-break and start.
  - Updates in the same cycle as the judge_valid strobe.
- Undefined: no combo port, no counter logic.

Test Plan:
- Tap head t=103, press when song_time=104 -> judge_valid once, code 00, addr 0->1, 4 cycles after key_down rise.
- Tap t=125, press at song_time=120 -> code 01 (good). Same setup, press at 117 -> code 10 (early miss). Same setup, press at 110 -> ignored, addr unchanged.
- Tap t=345, no press, song_time ramps to 352 -> miss at 352, addr+1. Hold-start t=2256, no press -> miss, addr+2.
- Hold 2256/2268, press at 2256:
  - Held past 2268 -> perfect on entry, then perfect at 2268; addr+2 total; hold_active high between.
  - Release at 2260 instead -> code 11.
- Stream reaches addr=NOTE_COUNT -> done=1. Assert start during a hold -> addr=0, hold_active=0, no strobe. Assert Reset_n low mid-strobe -> judge_valid=0 immediately.
- Orphan type-10 entry at head -> skipped in 1 cycle, no judge_valid.
